// File: rtl/muldiv_controller.sv
// Multi-cycle multiply/divide sequencer that owns the architectural HI/LO pair.
// MULT/MULTU use a shift-add multiplier and DIV/DIVU a restoring divider.
// Both run on magnitudes for WIDTH iterations, then apply a sign fixup and commit.
module muldiv_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op_div,
   input  logic             unsign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 op_div_q, op_div_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   // Multiplicand for multiply, divisor for divide.
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   // Multiply: {partial product high, multiplier/product low}.
   // Divide:   {remainder, quotient}.
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [WIDTH:0]       upper;
   logic [WIDTH:0]       rem_sh;
   logic                 ge;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;

   // Two's-complement absolute value; the most negative value maps to its own
   // bit pattern, which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                  input logic use_sign);
      logic signed [WIDTH-1:0] xs;
      xs = x;
      return (use_sign && xs < 0) ? WIDTH'(-xs) : x;
   endfunction

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return (~x) + WIDTH'(1);
   endfunction

   function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] x);
      return (~x) + (2*WIDTH)'(1);
   endfunction

   // Next-state, iteration datapath, sign fixup and HI/LO write selection.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_div_d = op_div_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      upper    = '0;
      rem_sh   = '0;
      ge       = 1'b0;
      prod     = '0;
      quo      = '0;
      rem      = '0;

      case (state_q)
         S_IDLE: begin
            // MTHI/MTLO are honoured only here; a start in the same cycle
            // is accepted too and its commit overwrites both registers.
            if (mthi_we) hi_d = wdata;
            if (mtlo_we) lo_d = wdata;
            if (start) begin
               state_d  = S_ITER;
               cnt_d    = '0;
               op_div_d = op_div;
               sign_a_d = ~unsign & a[WIDTH-1];
               sign_b_d = ~unsign & b[WIDTH-1];
               if (op_div) begin
                  opnd_d = magnitude(b, ~unsign);
                  acc_d  = {{WIDTH{1'b0}}, magnitude(a, ~unsign)};
               end else begin
                  opnd_d = magnitude(a, ~unsign);
                  acc_d  = {{WIDTH{1'b0}}, magnitude(b, ~unsign)};
               end
            end
         end
         S_ITER: begin
            if (op_div_q) begin
               rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
               ge     = (rem_sh >= {1'b0, opnd_q});
               acc_d  = {ge ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0],
                         acc_q[WIDTH-2:0], ge};
            end else begin
               // The carry out of the add lands in the top bit after the shift.
               upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
               acc_d = {upper, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
            // Sign flags are zero in unsigned mode, so no fixup happens there.
            if (op_div_q) begin
               quo  = (sign_a_q ^ sign_b_q) ? negate(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
               rem  = sign_a_q ? negate(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
               // A zero divisor leaves the dividend as the remainder, so hi
               // already equals a; only the quotient is forced to all ones.
               hi_d = rem;
               lo_d = (opnd_q == '0) ? {WIDTH{1'b1}} : quo;
            end else begin
               prod = (sign_a_q ^ sign_b_q) ? negate_wide(acc_q) : acc_q;
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_d = (state_d != S_IDLE);
   assign done_d = (state_q == S_FIX);

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_div_q <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_div_q <= op_div_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench for muldiv_controller: reset, MTHI/MTLO, signed/unsigned
// multiply and divide corners, busy protection, back-to-back and reset abort.
module tb_muldiv_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, op_div, unsign, mthi_we, mtlo_we;
   logic [31:0] a, b, wdata;
   logic [31:0] hi, lo;
   logic        busy, done;

   int checks   = 0;
   int failures = 0;

   muldiv_controller #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (rst_n),
      .start   (start),
      .op_div  (op_div),
      .unsign  (unsign),
      .a       (a),
      .b       (b),
      .mthi_we (mthi_we),
      .mtlo_we (mtlo_we),
      .wdata   (wdata),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic d, input logic u, input logic [31:0] av, input logic [31:0] bv);
      op_div = d;
      unsign = u;
      a      = av;
      b      = bv;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      a      = $urandom;
      b      = $urandom;
   endtask

   // Bounded wait for done; lat counts edges after the start-sampling edge.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         tick();
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic d, input logic u,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo);
      int lat, bcnt;
      start_op(d, u, av, bv);
      wait_done(lat, bcnt);
      check({tag, "_lat"}, lat, 33);
      check({tag, "_done"}, {31'b0, done}, 1);
      check({tag, "_hi"}, hi, ehi);
      check({tag, "_lo"}, lo, elo);
   endtask

   initial begin
      int lat, bcnt;
      rst_n   = 1'b0;
      start   = 1'b0;
      op_div  = 1'b0;
      unsign  = 1'b0;
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      a       = '0;
      b       = '0;
      wdata   = '0;
      repeat (2) tick();
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      rst_n = 1'b1;
      tick();

      // MTHI then MTLO in IDLE
      mthi_we = 1'b1; wdata = 32'hAAAA5555;
      tick();
      mthi_we = 1'b0;
      check("mthi", hi, 32'hAAAA5555);
      mtlo_we = 1'b1; wdata = 32'h0F0F0F0F;
      tick();
      mtlo_we = 1'b0;
      check("mtlo", lo, 32'h0F0F0F0F);
      check("mtlo_hi_kept", hi, 32'hAAAA5555);

      // Unsigned multiply with busy/done timing
      start_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(lat, bcnt);
      check("multu_lat", lat, 33);
      check("multu_busy_cycles", bcnt, 33);
      check("multu_done", {31'b0, done}, 1);
      check("multu_busy_at_done", {31'b0, busy}, 0);
      check("multu_hi", hi, 32'hFFFFFFFE);
      check("multu_lo", lo, 32'h00000001);
      tick();
      check("multu_done_pulse", {31'b0, done}, 0);

      // Signed multiply and divide
      run_op("mult_neg", 1'b0, 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("div_negA", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_negB", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

      // Unsigned divide and corners
      run_op("divu", 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("divu_zero", 1'b1, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
      run_op("div_zero_neg", 1'b1, 1'b0, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
      run_op("div_ovf", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      // start and MTHI while busy are ignored
      start_op(1'b0, 1'b1, 32'd3, 32'd4);
      repeat (5) tick();
      op_div = 1'b1; a = 32'd9; b = 32'd9; start = 1'b1;
      mthi_we = 1'b1; wdata = 32'h00001234;
      tick();
      start = 1'b0; mthi_we = 1'b0;
      check("busy_mthi_ignored", hi, 32'h00000000);
      check("busy_still", {31'b0, busy}, 1);
      wait_done(lat, bcnt);
      check("busy_prot_done", {31'b0, done}, 1);
      check("busy_prot_hi", hi, 32'd0);
      check("busy_prot_lo", lo, 32'd12);
      tick();
      check("busy_no_queue", {31'b0, busy}, 0);

      // MTHI together with start: write lands, commit overwrites
      mthi_we = 1'b1; wdata = 32'h0000DEAD;
      start_op(1'b0, 1'b1, 32'd2, 32'd3);
      mthi_we = 1'b0;
      check("mthi_start_hi", hi, 32'h0000DEAD);
      check("mthi_start_busy", {31'b0, busy}, 1);
      wait_done(lat, bcnt);
      check("mthi_start_res_hi", hi, 32'd0);
      check("mthi_start_res_lo", lo, 32'd6);

      // Back-to-back: new start sampled in the done cycle
      start_op(1'b1, 1'b1, 32'd100, 32'd7);
      wait_done(lat, bcnt);
      check("b2b_first_lo", lo, 32'd14);
      check("b2b_first_hi", hi, 32'd2);
      start_op(1'b0, 1'b1, 32'd6, 32'd7);
      wait_done(lat, bcnt);
      check("b2b_done_to_done", lat + 1, 34);
      check("b2b_second_hi", hi, 32'd0);
      check("b2b_second_lo", lo, 32'd42);

      // Asynchronous reset in the middle of a multiply
      start_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_hi", hi, 0);
      check("rst_mid_lo", lo, 0);
      check("rst_mid_busy", {31'b0, busy}, 0);
      check("rst_mid_done", {31'b0, done}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_after_busy", {31'b0, busy}, 0);
      run_op("post_rst", 1'b0, 1'b1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
